// File: rtl/ex_madd_stage_pkg.sv
// Shared encodings for the execute stage: alu op/sel codes, MACC FSM states, helpers.
// Pure declarations, no state.
// No flow control lives here.
package ex_madd_stage_pkg;

  localparam int REG_W  = 32;
  localparam int DREG_W = 64;

  // result classes
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;
  localparam logic [2:0] EXE_RES_MUL   = 3'b101;

  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b00000100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b00000110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b00000111;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b00001010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b00001011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b01010111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b01011000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b01010101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [7:0] EXE_CLZ_OP   = 8'b10110000;
  localparam logic [7:0] EXE_CLO_OP   = 8'b10110001;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_MUL_OP   = 8'b10101001;
  localparam logic [7:0] EXE_MADD_OP  = 8'b10100110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b10101000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b10101010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b10101011;

  typedef enum logic {
    MACC_IDLE = 1'b0,
    MACC_ACC  = 1'b1
  } macc_state_e;

  function automatic logic is_macc_op(input logic [7:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

  // Leading run length of bit value 'ones' from the MSB; 32 when the word is uniform.
  function automatic logic [5:0] count_lead(input logic [31:0] v, input logic ones);
    logic [5:0] n;
    logic       done;
    n    = 6'd0;
    done = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!done && (v[i] == ones)) n = n + 6'd1;
      else done = 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ex_mult64.sv
// 32x32->64 multiplier, signed or unsigned, via magnitude multiply and sign fix-up.
// Purely combinational, zero latency.
// No flow control.
module ex_mult64 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [63:0] p
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] mag;

  assign a_neg = is_signed & a[31];
  assign b_neg = is_signed & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;
  assign mag   = {32'd0, a_mag} * {32'd0, b_mag};
  assign p     = (a_neg ^ b_neg) ? (~mag + 64'd1) : mag;

endmodule

// File: rtl/ex_madd_stage.sv
// Execute stage: ALU result, HI/LO write request, 2-cycle multiply-accumulate.
// Results are combinational; macc results appear one cycle after issue.
// Raises stallreq_o on the first macc cycle; stall_i freezes the MACC FSM.
module ex_madd_stage
  import ex_madd_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem_whilo_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        wb_whilo_i,
  input  logic [31:0] wb_hi_i,
  input  logic [31:0] wb_lo_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  macc_state_e state;
  logic [63:0] acc_prod;

  logic [31:0] hi_fwd;
  logic [31:0] lo_fwd;
  logic        is_macc;
  logic        is_msub;
  logic        mult_signed;
  logic [63:0] prod;

  logic        is_sub;
  logic [31:0] reg2_mux;
  logic [31:0] sum;
  logic        ovf;
  logic        trap_ovf;
  logic        lt_s;
  logic        lt_u;
  logic [31:0] result;

  // Youngest pending HI/LO write wins.
  always_comb begin
    hi_fwd = hi_i;
    lo_fwd = lo_i;
    if (mem_whilo_i) begin
      hi_fwd = mem_hi_i;
      lo_fwd = mem_lo_i;
    end else if (wb_whilo_i) begin
      hi_fwd = wb_hi_i;
      lo_fwd = wb_lo_i;
    end
  end

  assign is_macc     = is_macc_op(aluop_i);
  assign is_msub     = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
  assign mult_signed = (aluop_i == EXE_MUL_OP)  || (aluop_i == EXE_MULT_OP) ||
                       (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);

  ex_mult64 u_mult (
    .a        (reg1_i),
    .b        (reg2_i),
    .is_signed(mult_signed),
    .p        (prod)
  );

  // A non-macc op seen in ACC is a flush: drop the pending accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MACC_IDLE;
      acc_prod <= '0;
    end else if (state == MACC_IDLE) begin
      if (is_macc && !stall_i) begin
        acc_prod <= is_msub ? (~prod + 64'd1) : prod;
        state    <= MACC_ACC;
      end
    end else begin
      if (!is_macc || !stall_i) state <= MACC_IDLE;
    end
  end

  assign is_sub   = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
  assign reg2_mux = is_sub ? (~reg2_i + 32'd1) : reg2_i;
  assign sum      = reg1_i + reg2_mux;
  assign ovf      = (reg1_i[31] == reg2_mux[31]) && (sum[31] != reg1_i[31]);
  assign trap_ovf = ovf && ((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_ADDI_OP) ||
                            (aluop_i == EXE_SUB_OP));
  assign lt_s     = $signed(reg1_i) < $signed(reg2_i);
  assign lt_u     = reg1_i < reg2_i;

  always_comb begin
    result = '0;
    case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_OR_OP:  result = reg1_i | reg2_i;
          EXE_AND_OP: result = reg1_i & reg2_i;
          EXE_XOR_OP: result = reg1_i ^ reg2_i;
          EXE_NOR_OP: result = ~(reg1_i | reg2_i);
          default:    result = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP, EXE_SLLV_OP: result = reg2_i << reg1_i[4:0];
          EXE_SRL_OP, EXE_SRLV_OP: result = reg2_i >> reg1_i[4:0];
          EXE_SRA_OP, EXE_SRAV_OP: result = $signed(reg2_i) >>> reg1_i[4:0];
          default:                 result = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP:              result = hi_fwd;
          EXE_MFLO_OP:              result = lo_fwd;
          EXE_MOVN_OP, EXE_MOVZ_OP: result = reg1_i;
          default:                  result = '0;
        endcase
      end
      EXE_RES_ARITH: begin
        case (aluop_i)
          EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
          EXE_SUB_OP, EXE_SUBU_OP:     result = sum;
          EXE_SLT_OP, EXE_SLTI_OP:     result = {31'd0, lt_s};
          EXE_SLTU_OP, EXE_SLTIU_OP:   result = {31'd0, lt_u};
          EXE_CLZ_OP:                  result = {26'd0, count_lead(reg1_i, 1'b0)};
          EXE_CLO_OP:                  result = {26'd0, count_lead(reg1_i, 1'b1)};
          default:                     result = '0;
        endcase
      end
      EXE_RES_MUL: begin
        if (aluop_i == EXE_MUL_OP) result = prod[31:0];
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o    = wd_i;
      wreg_o  = wreg_i & ~trap_ovf;
      wdata_o = result;
      case (aluop_i)
        EXE_MULT_OP, EXE_MULTU_OP: begin
          whilo_o      = 1'b1;
          {hi_o, lo_o} = prod;
        end
        EXE_MTHI_OP: begin
          whilo_o = 1'b1;
          hi_o    = reg1_i;
          lo_o    = lo_fwd;
        end
        EXE_MTLO_OP: begin
          whilo_o = 1'b1;
          hi_o    = hi_fwd;
          lo_o    = reg1_i;
        end
        EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: begin
          if (state == MACC_ACC) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = {hi_fwd, lo_fwd} + acc_prod;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        default: whilo_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_madd_stage.sv
// Directed + randomized checks of ex_madd_stage against an arithmetic reference model.
module tb_ex_madd_stage;
  import ex_madd_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        mem_whilo_i;
  logic [31:0] mem_hi_i;
  logic [31:0] mem_lo_i;
  logic        wb_whilo_i;
  logic [31:0] wb_hi_i;
  logic [31:0] wb_lo_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  ex_madd_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i),
    .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
    .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
  endtask

  function automatic logic [63:0] fwd_hilo();
    if (mem_whilo_i) return {mem_hi_i, mem_lo_i};
    if (wb_whilo_i)  return {wb_hi_i, wb_lo_i};
    return {hi_i, lo_i};
  endfunction

  function automatic int lead_run(input logic [31:0] v, input logic bitv);
    int n = 0;
    while (n < 32 && v[31-n] == bitv) n++;
    return n;
  endfunction

  // Behavioural model of a single non-macc op.
  function automatic exp_t model(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] hl, input logic we);
    exp_t        e;
    longint      sa, sb, s;
    logic [31:0] nb;
    logic [63:0] u;
    e  = '{wreg: we, wdata: 32'd0, whilo: 1'b0, hi: 32'd0, lo: 32'd0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (sel)
      EXE_RES_LOGIC:
        case (op)
          EXE_OR_OP:  e.wdata = a | b;
          EXE_AND_OP: e.wdata = a & b;
          EXE_XOR_OP: e.wdata = a ^ b;
          EXE_NOR_OP: e.wdata = ~(a | b);
          default: ;
        endcase
      EXE_RES_SHIFT:
        case (op)
          EXE_SLL_OP: e.wdata = b << a[4:0];
          EXE_SRL_OP: e.wdata = b >> a[4:0];
          EXE_SRA_OP: begin s = sb >>> a[4:0]; e.wdata = s[31:0]; end
          default: ;
        endcase
      EXE_RES_MOVE:
        case (op)
          EXE_MFHI_OP: e.wdata = hl[63:32];
          EXE_MFLO_OP: e.wdata = hl[31:0];
          EXE_MOVN_OP, EXE_MOVZ_OP: e.wdata = a;
          default: ;
        endcase
      EXE_RES_ARITH:
        case (op)
          EXE_ADD_OP, EXE_SUB_OP: begin
            nb = (op == EXE_SUB_OP) ? (32'd0 - b) : b;
            s  = sa + longint'($signed(nb));
            e.wdata = s[31:0];
            if (s > 64'sd2147483647 || s < -64'sd2147483648) e.wreg = 1'b0;
          end
          EXE_ADDU_OP: e.wdata = a + b;
          EXE_SUBU_OP: e.wdata = a - b;
          EXE_SLT_OP:  e.wdata = (sa < sb) ? 32'd1 : 32'd0;
          EXE_SLTU_OP: e.wdata = (a < b) ? 32'd1 : 32'd0;
          EXE_CLZ_OP:  e.wdata = 32'(lead_run(a, 1'b0));
          EXE_CLO_OP:  e.wdata = 32'(lead_run(a, 1'b1));
          default: ;
        endcase
      EXE_RES_MUL:
        if (op == EXE_MUL_OP) begin s = sa * sb; e.wdata = s[31:0]; end
      default: ;
    endcase
    case (op)
      EXE_MULT_OP:  begin s = sa * sb; e.whilo = 1'b1; {e.hi, e.lo} = s; end
      EXE_MULTU_OP: begin u = {32'd0, a} * {32'd0, b}; e.whilo = 1'b1; {e.hi, e.lo} = u; end
      EXE_MTHI_OP:  begin e.whilo = 1'b1; e.hi = a; e.lo = hl[31:0]; end
      EXE_MTLO_OP:  begin e.whilo = 1'b1; e.hi = hl[63:32]; e.lo = a; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [63:0] macc_model(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] base);
    logic [63:0] p;
    if (op == EXE_MADD_OP || op == EXE_MSUB_OP) p = longint'($signed(a)) * longint'($signed(b));
    else p = {32'd0, a} * {32'd0, b};
    return (op == EXE_MADD_OP || op == EXE_MADDU_OP) ? base + p : base - p;
  endfunction

  task automatic pick_op(input int idx, output logic [7:0] op, output logic [2:0] sel);
    case (idx)
      0:  begin op = EXE_OR_OP;    sel = EXE_RES_LOGIC; end
      1:  begin op = EXE_AND_OP;   sel = EXE_RES_LOGIC; end
      2:  begin op = EXE_XOR_OP;   sel = EXE_RES_LOGIC; end
      3:  begin op = EXE_NOR_OP;   sel = EXE_RES_LOGIC; end
      4:  begin op = EXE_SLL_OP;   sel = EXE_RES_SHIFT; end
      5:  begin op = EXE_SRL_OP;   sel = EXE_RES_SHIFT; end
      6:  begin op = EXE_SRA_OP;   sel = EXE_RES_SHIFT; end
      7:  begin op = EXE_MFHI_OP;  sel = EXE_RES_MOVE;  end
      8:  begin op = EXE_MFLO_OP;  sel = EXE_RES_MOVE;  end
      9:  begin op = EXE_MOVN_OP;  sel = EXE_RES_MOVE;  end
      10: begin op = EXE_ADD_OP;   sel = EXE_RES_ARITH; end
      11: begin op = EXE_ADDU_OP;  sel = EXE_RES_ARITH; end
      12: begin op = EXE_SUB_OP;   sel = EXE_RES_ARITH; end
      13: begin op = EXE_SUBU_OP;  sel = EXE_RES_ARITH; end
      14: begin op = EXE_SLT_OP;   sel = EXE_RES_ARITH; end
      15: begin op = EXE_SLTU_OP;  sel = EXE_RES_ARITH; end
      16: begin op = EXE_CLZ_OP;   sel = EXE_RES_ARITH; end
      17: begin op = EXE_CLO_OP;   sel = EXE_RES_ARITH; end
      18: begin op = EXE_MUL_OP;   sel = EXE_RES_MUL;   end
      19: begin op = EXE_MULT_OP;  sel = EXE_RES_NOP;   end
      20: begin op = EXE_MULTU_OP; sel = EXE_RES_NOP;   end
      21: begin op = EXE_MTHI_OP;  sel = EXE_RES_NOP;   end
      22: begin op = EXE_MTLO_OP;  sel = EXE_RES_NOP;   end
      23: begin op = 8'hFF;        sel = EXE_RES_ARITH; end
      default: begin op = EXE_OR_OP; sel = 3'b111; end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wd"},    {59'd0, wd_o}, 64'd0);
    check({tag, ".wreg"},  {63'd0, wreg_o}, 64'd0);
    check({tag, ".wdata"}, {32'd0, wdata_o}, 64'd0);
    check({tag, ".whilo"}, {63'd0, whilo_o}, 64'd0);
    check({tag, ".hilo"},  {hi_o, lo_o}, 64'd0);
    check({tag, ".stall"}, {63'd0, stallreq_o}, 64'd0);
  endtask

  initial begin
    exp_t        e;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [63:0] base, res;

    rst = 1'b1; stall_i = 1'b0; wd_i = 5'd17; wreg_i = 1'b1;
    hi_i = 32'h0; lo_i = 32'h0;
    mem_whilo_i = 1'b0; mem_hi_i = 32'h0; mem_lo_i = 32'h0;
    wb_whilo_i = 1'b0; wb_hi_i = 32'h0; wb_lo_i = 32'h0;
    set_op(EXE_MADD_OP, EXE_RES_NOP, 32'd5, 32'd7);
    next_cycle();
    next_cycle();
    check_all_zero("reset");
    rst = 1'b0;
    set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);

    // signed overflow suppresses the write, unsigned add wraps
    next_cycle();
    set_op(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFFFFFF, 32'h1); #1;
    check("add_ovf.wreg", {63'd0, wreg_o}, 64'd0);
    set_op(EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFFFFFF, 32'h1); #1;
    check("addu.wdata", {32'd0, wdata_o}, 64'h80000000);
    check("addu.wreg", {63'd0, wreg_o}, 64'd1);
    set_op(EXE_SUB_OP, EXE_RES_ARITH, 32'h80000000, 32'h1); #1;
    check("sub_ovf.wreg", {63'd0, wreg_o}, 64'd0);
    set_op(EXE_CLZ_OP, EXE_RES_ARITH, 32'h0, 32'h0); #1;
    check("clz0", {32'd0, wdata_o}, 64'd32);
    set_op(EXE_CLO_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'h0); #1;
    check("clo1", {32'd0, wdata_o}, 64'd32);

    // forwarding priority
    hi_i = 32'd1; wb_hi_i = 32'd2; mem_hi_i = 32'd3;
    mem_whilo_i = 1'b1; wb_whilo_i = 1'b1;
    set_op(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0); #1;
    check("fwd_mem", {32'd0, wdata_o}, 64'd3);
    mem_whilo_i = 1'b0; #1;
    check("fwd_wb", {32'd0, wdata_o}, 64'd2);
    wb_whilo_i = 1'b0; #1;
    check("fwd_reg", {32'd0, wdata_o}, 64'd1);

    // madd 3*-2 onto 0:0xA
    hi_i = 32'h0; lo_i = 32'hA;
    next_cycle();
    set_op(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'hFFFFFFFE); #1;
    check("madd.c0.stall", {63'd0, stallreq_o}, 64'd1);
    check("madd.c0.whilo", {63'd0, whilo_o}, 64'd0);
    next_cycle();
    check("madd.c1.whilo", {63'd0, whilo_o}, 64'd1);
    check("madd.c1.hilo", {hi_o, lo_o}, 64'h4);
    check("madd.c1.stall", {63'd0, stallreq_o}, 64'd0);
    next_cycle();
    set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);

    // msubu 0xFFFFFFFF*2 from 0
    lo_i = 32'h0;
    next_cycle();
    set_op(EXE_MSUBU_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'd2); #1;
    check("msubu.c0.stall", {63'd0, stallreq_o}, 64'd1);
    next_cycle();
    check("msubu.c1.hilo", {hi_o, lo_o}, 64'hFFFFFFFE00000002);
    check("msubu.c1.whilo", {63'd0, whilo_o}, 64'd1);
    next_cycle();
    set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);

    // stall held in ACC, then release; then stall held in IDLE
    lo_i = 32'hA;
    next_cycle();
    set_op(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'hFFFFFFFE);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      stall_i = 1'b1; #1;
      check("acc_stall.whilo", {63'd0, whilo_o}, 64'd1);
      check("acc_stall.hilo", {hi_o, lo_o}, 64'h4);
      check("acc_stall.stall", {63'd0, stallreq_o}, 64'd0);
      next_cycle();
    end
    stall_i = 1'b0; #1;
    check("acc_release.hilo", {hi_o, lo_o}, 64'h4);
    next_cycle();
    stall_i = 1'b1; #1;
    check("idle_again.stall", {63'd0, stallreq_o}, 64'd1);
    check("idle_again.whilo", {63'd0, whilo_o}, 64'd0);
    next_cycle();
    check("idle_stall.stall", {63'd0, stallreq_o}, 64'd1);
    check("idle_stall.whilo", {63'd0, whilo_o}, 64'd0);
    stall_i = 1'b0;
    set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);

    // reset on the ACC cycle
    next_cycle();
    set_op(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'hFFFFFFFE);
    next_cycle();
    rst = 1'b1; #1;
    check_all_zero("rst_acc");
    next_cycle();
    rst = 1'b0; stall_i = 1'b1; #1;
    check("post_rst.stall", {63'd0, stallreq_o}, 64'd1);
    check("post_rst.whilo", {63'd0, whilo_o}, 64'd0);
    stall_i = 1'b0;
    set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h00F0, 32'h1234); #1;
    check("ori.stall", {63'd0, stallreq_o}, 64'd0);
    check("ori.wdata", {32'd0, wdata_o}, 64'h12F4);
    check("ori.whilo", {63'd0, whilo_o}, 64'd0);

    // flush in ACC
    next_cycle();
    set_op(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd3);
    next_cycle();
    set_op(EXE_XOR_OP, EXE_RES_LOGIC, 32'hFF00, 32'h0FF0); #1;
    check("flush.wdata", {32'd0, wdata_o}, 64'hF0F0);
    check("flush.whilo", {63'd0, whilo_o}, 64'd0);
    check("flush.stall", {63'd0, stallreq_o}, 64'd0);
    next_cycle();
    set_op(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd3); stall_i = 1'b1; #1;
    check("flush.idle", {63'd0, stallreq_o}, 64'd1);
    stall_i = 1'b0;
    set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);

    // randomized single-cycle ops
    for (int n = 0; n < 150; n++) begin
      next_cycle();
      pick_op(int'($urandom_range(0, 24)), op, sel);
      set_op(op, sel, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) reg1_i = reg1_i >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) reg1_i = ~reg1_i;
      wd_i = 5'($urandom); wreg_i = 1'($urandom);
      hi_i = $urandom; lo_i = $urandom;
      mem_whilo_i = 1'($urandom); mem_hi_i = $urandom; mem_lo_i = $urandom;
      wb_whilo_i = 1'($urandom); wb_hi_i = $urandom; wb_lo_i = $urandom;
      #1;
      e = model(op, sel, reg1_i, reg2_i, fwd_hilo(), wreg_i);
      check("rnd.wd", {59'd0, wd_o}, {59'd0, wd_i});
      check("rnd.wreg", {63'd0, wreg_o}, {63'd0, e.wreg});
      check("rnd.wdata", {32'd0, wdata_o}, {32'd0, e.wdata});
      check("rnd.whilo", {63'd0, whilo_o}, {63'd0, e.whilo});
      check("rnd.hilo", {hi_o, lo_o}, {e.hi, e.lo});
      check("rnd.stall", {63'd0, stallreq_o}, 64'd0);
    end

    // randomized back-to-back macc; each sees the previous result via mem forwarding
    mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;
    hi_i = $urandom; lo_i = $urandom;
    for (int n = 0; n < 16; n++) begin
      next_cycle();
      case ($urandom_range(0, 3))
        0: op = EXE_MADD_OP;
        1: op = EXE_MADDU_OP;
        2: op = EXE_MSUB_OP;
        default: op = EXE_MSUBU_OP;
      endcase
      set_op(op, EXE_RES_NOP, $urandom, $urandom);
      #1;
      check("mrnd.c0.stall", {63'd0, stallreq_o}, 64'd1);
      check("mrnd.c0.whilo", {63'd0, whilo_o}, 64'd0);
      base = fwd_hilo();
      next_cycle();
      res = macc_model(op, reg1_i, reg2_i, base);
      check("mrnd.c1.whilo", {63'd0, whilo_o}, 64'd1);
      check("mrnd.c1.hilo", {hi_o, lo_o}, res);
      check("mrnd.c1.stall", {63'd0, stallreq_o}, 64'd0);
      mem_whilo_i = 1'b1; mem_hi_i = res[63:32]; mem_lo_i = res[31:0];
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule
